// File: rtl/dff_share_arbiter.sv
// Round-robin arbiter that sequences loads from NREQ producers into one
// shared WIDTH-bit register. Each grant loads q once and lasts at most HOLD
// cycles. Ownership then rotates to the requester after the last owner.
module dff_share_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int HOLD  = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*WIDTH-1:0]     d_bus,
    output logic [NREQ-1:0]           gnt,
    output logic [$clog2(NREQ)-1:0]   owner,
    output logic [WIDTH-1:0]          q,
    output logic                      valid,
    output logic                      busy
);

    localparam int OW = $clog2(NREQ);
    localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t            state, state_n;
    logic [OW-1:0]     ptr, ptr_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic [NREQ-1:0]   gnt_n;
    logic [OW-1:0]     owner_n;
    logic [WIDTH-1:0]  q_n;
    logic              valid_n;
    logic              busy_n;
    logic [OW-1:0]     win;
    logic              found;

    // Pick the first active request at or after ptr, wrapping around.
    always_comb begin
        win   = '0;
        found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            logic [OW-1:0] idx;
            idx = OW'((int'(ptr) + i) % NREQ);
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    // Next-state and next-output logic; the shared register only changes on a new grant.
    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        cnt_n   = cnt;
        gnt_n   = gnt;
        owner_n = owner;
        q_n     = q;
        valid_n = 1'b0;
        busy_n  = busy;
        case (state)
            IDLE: begin
                if (found) begin
                    state_n = GRANT;
                    gnt_n   = NREQ'(1) << win;
                    owner_n = win;
                    q_n     = d_bus[int'(win)*WIDTH +: WIDTH];
                    valid_n = 1'b1;
                    busy_n  = 1'b1;
                    cnt_n   = CW'(HOLD - 1);
                end
            end
            GRANT: begin
                if (!req[owner] || cnt == '0) begin
                    state_n = IDLE;
                    gnt_n   = '0;
                    busy_n  = 1'b0;
                    ptr_n   = (owner == OW'(NREQ - 1)) ? '0 : owner + OW'(1);
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            default: begin
                state_n = IDLE;
                gnt_n   = '0;
                busy_n  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any grant and clears q at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            ptr   <= '0;
            cnt   <= '0;
            gnt   <= '0;
            owner <= '0;
            q     <= '0;
            valid <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
            cnt   <= cnt_n;
            gnt   <= gnt_n;
            owner <= owner_n;
            q     <= q_n;
            valid <= valid_n;
            busy  <= busy_n;
        end
    end

endmodule

// File: tb/tb_dff_share_arbiter.sv
// Self-checking bench for dff_share_arbiter: a behavioural reference model
// pushes expected outputs into a scoreboard queue as each input vector is
// driven, and they are popped and compared after the following clock edge.
module tb_dff_share_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int HOLD  = 2;

    logic                  clk;
    logic                  reset;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] d_bus;
    logic [NREQ-1:0]       gnt;
    logic [1:0]            owner;
    logic [WIDTH-1:0]      q;
    logic                  valid;
    logic                  busy;

    typedef struct packed {
        logic [NREQ-1:0]  gnt;
        logic [1:0]       owner;
        logic [WIDTH-1:0] q;
        logic             valid;
        logic             busy;
    } exp_t;

    exp_t sb[$];

    int checks;
    int errors;

    // Reference model state
    bit              m_granting;
    int              m_ptr;
    int              m_cnt;
    int              m_owner;
    logic [NREQ-1:0] m_gnt;
    logic [WIDTH-1:0] m_q;
    bit              m_valid;
    bit              m_busy;

    dff_share_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .HOLD(HOLD)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .d_bus (d_bus),
        .gnt   (gnt),
        .owner (owner),
        .q     (q),
        .valid (valid),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic modelReset();
        m_granting = 1'b0;
        m_ptr      = 0;
        m_cnt      = 0;
        m_owner    = 0;
        m_gnt      = '0;
        m_q        = '0;
        m_valid    = 1'b0;
        m_busy     = 1'b0;
    endtask

    // Advance the model by one clock edge for the given inputs.
    task automatic modelStep(input logic [NREQ-1:0] r, input logic [NREQ*WIDTH-1:0] d);
        int w;
        m_valid = 1'b0;
        if (!m_granting) begin
            if (r != '0) begin
                w = m_ptr;
                while (r[w] == 1'b0) w = (w + 1) % NREQ;
                m_granting = 1'b1;
                m_gnt      = '0;
                m_gnt[w]   = 1'b1;
                m_owner    = w;
                m_q        = d[w*WIDTH +: WIDTH];
                m_valid    = 1'b1;
                m_busy     = 1'b1;
                m_cnt      = HOLD;
            end
        end else begin
            m_cnt = m_cnt - 1;
            if (r[m_owner] == 1'b0 || m_cnt == 0) begin
                m_granting = 1'b0;
                m_gnt      = '0;
                m_busy     = 1'b0;
                m_ptr      = (m_owner + 1) % NREQ;
            end
        end
    endtask

    // Drive one input vector, predict the post-edge outputs, then compare them.
    task automatic applyStimulus(input logic [NREQ-1:0] r, input logic [NREQ*WIDTH-1:0] d);
        exp_t e;
        req   = r;
        d_bus = d;
        modelStep(r, d);
        e.gnt   = m_gnt;
        e.owner = 2'(m_owner);
        e.q     = m_q;
        e.valid = m_valid;
        e.busy  = m_busy;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard: got empty queue expected an entry");
        end else begin
            e = sb.pop_front();
            checkOutput("gnt",   32'(gnt),   32'(e.gnt));
            checkOutput("owner", 32'(owner), 32'(e.owner));
            checkOutput("q",     32'(q),     32'(e.q));
            checkOutput("valid", 32'(valid), 32'(e.valid));
            checkOutput("busy",  32'(busy),  32'(e.busy));
        end
    endtask

    task automatic checkIdleZero(input string tag);
        checkOutput({tag, "_gnt"},   32'(gnt),   32'h0);
        checkOutput({tag, "_owner"}, 32'(owner), 32'h0);
        checkOutput({tag, "_q"},     32'(q),     32'h0);
        checkOutput({tag, "_valid"}, 32'(valid), 32'h0);
        checkOutput({tag, "_busy"},  32'(busy),  32'h0);
    endtask

    task automatic doReset();
        reset = 1'b1;
        req   = '0;
        #2;
        checkIdleZero("reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        modelReset();
        sb.delete();
    endtask

    initial begin
        logic [NREQ*WIDTH-1:0] d;
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        req    = '0;
        d_bus  = '0;
        modelReset();

        // 1: single requester 1, then confirm pointer moved to 2
        doReset();
        d = {8'h44, 8'h33, 8'hA5, 8'h11};
        applyStimulus(4'b0010, d);
        checkOutput("t1_gnt",   32'(gnt),   32'h2);
        checkOutput("t1_owner", 32'(owner), 32'h1);
        checkOutput("t1_q",     32'(q),     32'hA5);
        checkOutput("t1_valid", 32'(valid), 32'h1);
        applyStimulus(4'b0010, d);
        checkOutput("t1_valid2", 32'(valid), 32'h0);
        applyStimulus(4'b0010, d);
        checkOutput("t1_rel", 32'(gnt), 32'h0);
        applyStimulus(4'b0000, d);
        applyStimulus(4'b1111, d);
        checkOutput("t1_ptr2", 32'(owner), 32'h2);
        for (int i = 0; i < 3; i++) applyStimulus(4'b0000, d);

        // 2: requesters 0 and 3 simultaneously
        doReset();
        d = {8'hD3, 8'h22, 8'h11, 8'hD0};
        for (int i = 0; i < 7; i++) begin
            applyStimulus(4'b1001, d);
            if (i == 3) checkOutput("t2_q3", 32'(q), 32'hD3);
            if (i == 6) checkOutput("t2_q0", 32'(q), 32'hD0);
        end
        applyStimulus(4'b0000, d);
        applyStimulus(4'b0000, d);

        // 3: early release after one cycle
        d = {8'h00, 8'h3C, 8'h00, 8'h00};
        applyStimulus(4'b0100, d);
        checkOutput("t3_gnt", 32'(gnt), 32'h4);
        applyStimulus(4'b0000, d);
        checkOutput("t3_busy", 32'(busy), 32'h0);
        checkOutput("t3_q",    32'(q),    32'h3C);
        applyStimulus(4'b0000, d);

        // 4: all requesting, pointer wraps 3 -> 0
        doReset();
        d = {8'h04, 8'h03, 8'h02, 8'h01};
        for (int i = 0; i < 15; i++) applyStimulus(4'b1111, d);
        checkOutput("t4_wrap", 32'(owner), 32'h0);

        // 5: asynchronous reset in the middle of a grant
        doReset();
        d = {8'h00, 8'h00, 8'h00, 8'h5A};
        applyStimulus(4'b0001, d);
        applyStimulus(4'b0001, d);
        #2;
        reset = 1'b1;
        #1;
        checkIdleZero("t5_async");
        #1;
        reset = 1'b0;
        modelReset();
        sb.delete();
        applyStimulus(4'b0001, d);
        checkOutput("t5_regrant", 32'(gnt), 32'h1);
        applyStimulus(4'b0001, d);
        applyStimulus(4'b0000, d);

        // 6: d_bus changes during a grant do not reach q
        doReset();
        d = {8'h11, 8'h00, 8'h00, 8'h00};
        applyStimulus(4'b1000, d);
        d = {8'h22, 8'h00, 8'h00, 8'h00};
        applyStimulus(4'b1000, d);
        checkOutput("t6_q",     32'(q),     32'h11);
        checkOutput("t6_valid", 32'(valid), 32'h0);
        applyStimulus(4'b0000, d);
        checkOutput("t6_qend", 32'(q), 32'h11);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
